// File: rtl/clock_rate_select.sv
// System-clock generator for the breadboard CPU: divides the master clock into a
// one-cycle enable (sys_ce) plus a probe square wave, with halt and single-step.
module clock_rate_select #(
  parameter int                          NUM_RATES = 4,
  parameter int                          CNT_W     = 16,
  parameter logic [NUM_RATES*CNT_W-1:0]  DIVS      = {16'd1000, 16'd8, 16'd2, 16'd1},
  parameter int                          DEBOUNCE  = 4,
  localparam int                         SEL_W     = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             hlt,
  output logic             sys_ce,
  output logic             sys_clk,
  output logic [SEL_W-1:0] active_sel,
  output logic             switching,
  output logic             halted
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [1:0] {EFF_RUN, EFF_HALT, EFF_STEP} eff_t;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if (int'(s) >= NUM_RATES) return SEL_W'(NUM_RATES - 1);
    return s;
  endfunction

  // A zero divide ratio would never wrap, so it is read as 1.
  function automatic logic [CNT_W-1:0] div_of(input logic [SEL_W-1:0] idx);
    logic [CNT_W-1:0] d;
    d = CNT_W'(1);
    for (int i = 0; i < NUM_RATES; i++) begin
      if (idx == SEL_W'(i)) d = DIVS[i*CNT_W +: CNT_W];
    end
    if (d == '0) d = CNT_W'(1);
    return d;
  endfunction

  logic             step_p0, step_p1;
  logic             db_level, db_level_n;
  logic [DB_W-1:0]  db_cnt, db_cnt_n;
  logic             db_rise, db_rise_n;
  logic [SEL_W-1:0] pending, pending_n;
  logic [SEL_W-1:0] active_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_now;
  logic             ce_n, clk_n, switching_n, halted_n;
  eff_t             eff;

  always_comb begin
    pending_n  = clamp_sel(sel);
    halted_n   = halted | hlt;

    db_level_n = db_level;
    db_cnt_n   = '0;
    db_rise_n  = 1'b0;
    if (step_p1 != db_level) begin
      if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        db_level_n = step_p1;
        db_rise_n  = step_p1;
      end else begin
        db_cnt_n = db_cnt + DB_W'(1);
      end
    end

    eff = EFF_HALT;
    if (!halted) begin
      case (mode)
        2'b00:   eff = EFF_RUN;
        2'b10:   eff = EFF_STEP;
        default: eff = EFF_HALT;
      endcase
    end

    // Outside a RUN period boundary the counter stays cleared and the rate
    // tracks the request directly, so leaving HALT/STEP starts a fresh period.
    active_n = pending;
    cnt_n    = '0;
    ce_n     = 1'b0;
    div_now  = '0;
    case (eff)
      EFF_RUN: begin
        if (!sys_ce) active_n = active_sel;
        div_now = div_of(active_n);
        if (cnt >= div_now - CNT_W'(1)) ce_n = 1'b1;
        else                            cnt_n = cnt + CNT_W'(1);
      end
      EFF_STEP: ce_n = db_rise;
      default:  ;
    endcase

    clk_n       = sys_clk ^ ce_n;
    switching_n = (pending_n != active_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_p0    <= 1'b0;
      step_p1    <= 1'b0;
      db_level   <= 1'b0;
      db_cnt     <= '0;
      db_rise    <= 1'b0;
      pending    <= '0;
      active_sel <= '0;
      cnt        <= '0;
      sys_ce     <= 1'b0;
      sys_clk    <= 1'b0;
      switching  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      step_p0    <= step_btn;
      step_p1    <= step_p0;
      db_level   <= db_level_n;
      db_cnt     <= db_cnt_n;
      db_rise    <= db_rise_n;
      pending    <= pending_n;
      active_sel <= active_n;
      cnt        <= cnt_n;
      sys_ce     <= ce_n;
      sys_clk    <= clk_n;
      switching  <= switching_n;
      halted     <= halted_n;
    end
  end

endmodule

// File: tb/tb_clock_rate_select.sv
// Self-checking bench for clock_rate_select: rate table plus hand-written
// switch, step, halt and hlt sequences, with a pulse-time scoreboard.
module tb_clock_rate_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [1:0] mode = 2'b00;
  logic       step_btn = 1'b0;
  logic       hlt = 1'b0;
  logic       sys_ce, sys_clk, switching, halted;
  logic [1:0] active_sel;

  logic [2:0] sel_c = 3'd7;
  logic [1:0] mode_c = 2'b01;
  logic       step_c = 1'b0;
  logic       hlt_c = 1'b0;
  logic       sys_ce_c, sys_clk_c, switching_c, halted_c;
  logic [2:0] active_c;

  clock_rate_select u_dut (
    .clk(clk), .rst(rst), .sel(sel), .mode(mode), .step_btn(step_btn), .hlt(hlt),
    .sys_ce(sys_ce), .sys_clk(sys_clk), .active_sel(active_sel),
    .switching(switching), .halted(halted)
  );

  clock_rate_select #(
    .NUM_RATES(5),
    .DIVS({16'd3, 16'd1000, 16'd8, 16'd2, 16'd1})
  ) u_clamp (
    .clk(clk), .rst(rst), .sel(sel_c), .mode(mode_c), .step_btn(step_c), .hlt(hlt_c),
    .sys_ce(sys_ce_c), .sys_clk(sys_clk_c), .active_sel(active_c),
    .switching(switching_c), .halted(halted_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int mark = 0;

  typedef struct {
    logic [1:0] sel;
    int         d;
    logic [1:0] act;
  } rate_vec_t;
  rate_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every sys_ce pulse must match the next scheduled pulse cycle.
  int e_cyc;
  always @(negedge clk) begin
    if (sys_ce === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sys_ce_unexpected: pulse at cycle %0d, none scheduled", cyc);
      end else begin
        e_cyc = exp_q.pop_front();
        if (e_cyc != cyc) begin
          n_bad++;
          $display("FAIL sys_ce_time: pulse at cycle %0d, required at %0d", cyc, e_cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [1:0] s, input logic [1:0] m);
    check("sched_drained", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b1;
    sel = s;
    mode = m;
    hlt = 1'b0;
    step_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mark = cyc;
  endtask

  task automatic stop();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "time limit reached");
  end

  initial begin
    vecs[0] = '{sel: 2'd0, d: 1,    act: 2'd0};
    vecs[1] = '{sel: 2'd1, d: 2,    act: 2'd1};
    vecs[2] = '{sel: 2'd2, d: 8,    act: 2'd2};
    vecs[3] = '{sel: 2'd3, d: 1000, act: 2'd3};

    repeat (2) @(posedge clk);
    #1;
    check("rst_sys_ce", sys_ce, 0);
    check("rst_sys_clk", sys_clk, 0);
    check("rst_active_sel", active_sel, 0);
    check("rst_switching", switching, 0);
    check("rst_halted", halted, 0);

    // HALT from reset: no pulses; out-of-range sel clamps on the 5-rate copy.
    start(2'd0, 2'b01);
    wait_cyc(mark + 3);
    check("clamp_active_sel", active_c, 4);
    check("clamp_switching", switching_c, 0);
    check("halt_sys_clk", sys_clk, 0);
    stop();

    // After reset active_sel=0 (D=1) fires once, then the requested rate runs.
    for (int v = 0; v < 4; v++) begin
      start(vecs[v].sel, 2'b00);
      for (int k = 0; k < 4; k++) exp_q.push_back(mark + 1 + k * vecs[v].d);
      for (int k = 0; k < 4; k++) begin
        wait_cyc(mark + 1 + k * vecs[v].d);
        check("tbl_sys_ce", sys_ce, 1);
        check("tbl_sys_clk", sys_clk, (k + 1) % 2);
        if (k > 0) begin
          check("tbl_active_sel", active_sel, vecs[v].act);
          check("tbl_switching", switching, 0);
        end
      end
      stop();
    end

    // Rate switch mid-period, with sel bouncing before the boundary.
    start(2'd2, 2'b00);
    exp_q.push_back(mark + 1);
    exp_q.push_back(mark + 9);
    exp_q.push_back(mark + 17);
    exp_q.push_back(mark + 19);
    exp_q.push_back(mark + 21);
    exp_q.push_back(mark + 23);
    wait_cyc(mark + 12); sel = 2'd1;
    wait_cyc(mark + 13);
    check("sw_switching_on", switching, 1);
    check("sw_active_old", active_sel, 2);
    wait_cyc(mark + 14); sel = 2'd3;
    wait_cyc(mark + 15); sel = 2'd1;
    wait_cyc(mark + 16);
    check("sw_switching_hold", switching, 1);
    wait_cyc(mark + 17);
    check("sw_boundary_ce", sys_ce, 1);
    check("sw_boundary_active", active_sel, 2);
    wait_cyc(mark + 18);
    check("sw_active_new", active_sel, 1);
    check("sw_switching_off", switching, 0);
    check("sw_ce_low", sys_ce, 0);
    wait_cyc(mark + 23);
    stop();

    // STEP: press completed in HALT is ignored, bounce ignored, held press = one pulse.
    start(2'd0, 2'b01);
    wait_cyc(mark + 2);  step_btn = 1'b1;
    wait_cyc(mark + 14); mode = 2'b10;
    wait_cyc(mark + 24);
    check("step_no_stale_pulse", sys_clk, 0);
    step_btn = 1'b0;
    wait_cyc(mark + 36); step_btn = 1'b1;
    wait_cyc(mark + 39); step_btn = 1'b0;
    wait_cyc(mark + 50); step_btn = 1'b1;
    exp_q.push_back(mark + 57);
    wait_cyc(mark + 57);
    check("step_pulse", sys_ce, 1);
    check("step_sys_clk", sys_clk, 1);
    wait_cyc(mark + 58);
    check("step_pulse_one_cycle", sys_ce, 0);
    wait_cyc(mark + 70); step_btn = 1'b0;
    wait_cyc(mark + 80); sel = 2'd2;
    wait_cyc(mark + 81);
    check("step_switching", switching, 1);
    wait_cyc(mark + 82);
    check("step_active_load", active_sel, 2);
    check("step_switching_off", switching, 0);
    wait_cyc(mark + 95);
    check("step_single_pulse", sys_clk, 1);
    stop();

    // HALT at counter 500 of a D=1000 period, resume, then async reset mid-period.
    start(2'd3, 2'b00);
    exp_q.push_back(mark + 1);
    exp_q.push_back(mark + 1551);
    exp_q.push_back(mark + 2551);
    wait_cyc(mark + 501); mode = 2'b01;
    wait_cyc(mark + 520);
    check("halt_ce", sys_ce, 0);
    check("halt_clk_held", sys_clk, 1);
    check("halt_active", active_sel, 3);
    wait_cyc(mark + 551); mode = 2'b00;
    wait_cyc(mark + 2551);
    check("resume_ce", sys_ce, 1);
    check("resume_clk", sys_clk, 1);
    wait_cyc(mark + 2700);
    #3;
    rst = 1'b1;
    #1;
    check("arst_sys_ce", sys_ce, 0);
    check("arst_sys_clk", sys_clk, 0);
    check("arst_active_sel", active_sel, 0);
    check("arst_switching", switching, 0);
    check("arst_halted", halted, 0);
    start(2'd2, 2'b00);
    exp_q.push_back(mark + 1);
    exp_q.push_back(mark + 9);
    exp_q.push_back(mark + 17);
    wait_cyc(mark + 1);
    check("post_rst_active", active_sel, 0);
    check("post_rst_switching", switching, 1);
    wait_cyc(mark + 2);
    check("post_rst_active_load", active_sel, 2);
    wait_cyc(mark + 17);
    stop();

    // hlt coinciding with a firing edge: that pulse survives, later ones are blocked.
    start(2'd1, 2'b00);
    exp_q.push_back(mark + 1);
    exp_q.push_back(mark + 3);
    exp_q.push_back(mark + 5);
    wait_cyc(mark + 4); hlt = 1'b1;
    wait_cyc(mark + 5); hlt = 1'b0;
    check("hlt_pulse_kept", sys_ce, 1);
    check("hlt_latched", halted, 1);
    wait_cyc(mark + 25);
    check("hlt_still_latched", halted, 1);
    check("hlt_clk_held", sys_clk, 1);
    mode = 2'b10;
    step_btn = 1'b1;
    wait_cyc(mark + 40); step_btn = 1'b0;
    wait_cyc(mark + 55);
    check("hlt_blocks_step", sys_ce, 0);
    check("hlt_sticky", halted, 1);
    #3;
    rst = 1'b1;
    #1;
    check("hlt_cleared_by_rst", halted, 0);
    start(2'd1, 2'b00);
    exp_q.push_back(mark + 1);
    exp_q.push_back(mark + 3);
    exp_q.push_back(mark + 5);
    wait_cyc(mark + 5);
    check("hlt_resume_ce", sys_ce, 1);
    stop();

    repeat (3) @(posedge clk);
    #1;
    check("sched_drained_final", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
